// File: rtl/matrix_feeder_if.sv
// Host/array-side bus of the matrix feeder: bank loading, arming, element
// requests and the served A/B pair with its status flags.
interface matrix_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  load_en;
    logic                  load_sel;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  arm;
    logic                  start_compute;
    logic                  read_data;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] data_in_A;
    logic [DATA_WIDTH-1:0] data_in_B;
    logic                  data_out_vld;
    logic                  busy;
    logic                  xfer_done;
    logic                  err;

    modport master (
        output load_en, load_sel, load_addr, load_data, arm, start_compute, read_data,
        input  data_valid, data_in_A, data_in_B, data_out_vld, busy, xfer_done, err
    );

    modport slave (
        input  load_en, load_sel, load_addr, load_data, arm, start_compute, read_data,
        output data_valid, data_in_A, data_in_B, data_out_vld, busy, xfer_done, err
    );
endinterface

// File: rtl/matrix_feeder.sv
// Operand source for the 4x4 systolic array: two host-loaded banks served one
// A/B pair per read_data request, with a one-cycle arm handshake.
module matrix_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    matrix_feeder_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t                state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] ptr_r, ptr_next_s, rd_idx_s;
    logic [DATA_WIDTH-1:0] bank_a_r [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] bank_b_r [0:DEPTH-1];
    logic                  serve_s, last_s, write_s, err_set_s;
    logic                  data_valid_r, data_out_vld_r, busy_r, xfer_done_r, err_r;
    logic [DATA_WIDTH-1:0] data_a_r, data_b_r;

    // Next-state, pointer update, bank write enable and protocol error detection
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        serve_s      = 1'b0;
        last_s       = 1'b0;
        write_s      = 1'b0;
        err_set_s    = 1'b0;
        // start_compute rewinds the pointer and, with read_data, serves element 0
        if (bus.start_compute) begin
            rd_idx_s   = '0;
            ptr_next_s = '0;
        end else begin
            rd_idx_s   = ptr_r;
        end
        case (state_r)
            ST_IDLE: begin
                write_s = bus.load_en;
                if (bus.arm) begin
                    state_next_s = ST_ARM;
                end else begin
                    state_next_s = ST_IDLE;
                end
                err_set_s = bus.read_data;
            end
            ST_ARM: begin
                state_next_s = ST_SERVE;
                err_set_s    = bus.load_en | bus.arm | bus.read_data;
            end
            ST_SERVE: begin
                err_set_s = bus.load_en | bus.arm;
                if (bus.read_data) begin
                    serve_s = 1'b1;
                    if (rd_idx_s == ADDR_WIDTH'(DEPTH - 1)) begin
                        last_s       = 1'b1;
                        ptr_next_s   = '0;
                        state_next_s = ST_IDLE;
                    end else begin
                        ptr_next_s   = rd_idx_s + ADDR_WIDTH'(1);
                    end
                end else begin
                    serve_s = 1'b0;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                ptr_next_s   = '0;
            end
        endcase
    end

    // Control state, pointer and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
            err_r   <= err_r | err_set_s;
        end
    end

    // Operand banks, cleared on reset and written by the host only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_a_r[i] <= '0;
                bank_b_r[i] <= '0;
            end
        end else if (write_s) begin
            if (bus.load_sel) begin
                bank_b_r[bus.load_addr] <= bus.load_data;
            end else begin
                bank_a_r[bus.load_addr] <= bus.load_data;
            end
        end
    end

    // Registered outputs; data is zeroed whenever no element is being served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid_r   <= 1'b0;
            data_out_vld_r <= 1'b0;
            data_a_r       <= '0;
            data_b_r       <= '0;
            busy_r         <= 1'b0;
            xfer_done_r    <= 1'b0;
        end else begin
            data_valid_r   <= (state_next_s == ST_ARM);
            data_out_vld_r <= serve_s;
            data_a_r       <= serve_s ? bank_a_r[rd_idx_s] : '0;
            data_b_r       <= serve_s ? bank_b_r[rd_idx_s] : '0;
            busy_r         <= (state_next_s != ST_IDLE);
            xfer_done_r    <= last_s;
        end
    end

    assign bus.data_valid   = data_valid_r;
    assign bus.data_out_vld = data_out_vld_r;
    assign bus.data_in_A    = data_a_r;
    assign bus.data_in_B    = data_b_r;
    assign bus.busy         = busy_r;
    assign bus.xfer_done    = xfer_done_r;
    assign bus.err          = err_r;
endmodule

// File: tb/tb_matrix_feeder.sv
// Self-checking bench for matrix_feeder: a cycle model pushes the expected
// output record for each edge into a scoreboard that is popped after the edge.
module tb_matrix_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_feeder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus();
    matrix_feeder #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic       dv;
        logic [7:0] a;
        logic [7:0] b;
        logic       vld;
        logic       busy;
        logic       done;
        logic       err;
    } rec_t;

    rec_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] m_a [16];
    logic [7:0] m_b [16];
    int   m_state = 0;
    int   m_ptr = 0;
    logic m_err = 1'b0;

    // One clock: model the edge, queue the expectation, drive, pop and compare.
    task automatic tick(input logic ld, input logic sel, input logic [3:0] addr,
                        input logic [7:0] dat, input logic arm_i, input logic sc,
                        input logic rd, input string tag);
        rec_t e, act;
        int   n_state, idx;
        e = '0;
        n_state = m_state;
        idx = sc ? 0 : m_ptr;
        if (sc) m_ptr = 0;
        case (m_state)
            0: begin
                if (ld) begin
                    if (sel) m_b[addr] = dat; else m_a[addr] = dat;
                end
                if (arm_i) n_state = 1;
                if (rd) m_err = 1'b1;
            end
            1: begin
                n_state = 2;
                if (ld || arm_i || rd) m_err = 1'b1;
            end
            default: begin
                if (ld || arm_i) m_err = 1'b1;
                if (rd) begin
                    e.vld = 1'b1;
                    e.a = m_a[idx];
                    e.b = m_b[idx];
                    if (idx == 15) begin
                        e.done = 1'b1;
                        m_ptr = 0;
                        n_state = 0;
                    end else begin
                        m_ptr = idx + 1;
                    end
                end
            end
        endcase
        m_state = n_state;
        e.dv = (n_state == 1);
        e.busy = (n_state != 0);
        e.err = m_err;
        sb.push_back(e);

        bus.load_en = ld; bus.load_sel = sel; bus.load_addr = addr; bus.load_data = dat;
        bus.arm = arm_i; bus.start_compute = sc; bus.read_data = rd;
        @(posedge clk);
        #1;
        bus.load_en = 1'b0; bus.arm = 1'b0; bus.start_compute = 1'b0; bus.read_data = 1'b0;

        act = {bus.data_valid, bus.data_in_A, bus.data_in_B, bus.data_out_vld,
               bus.busy, bus.xfer_done, bus.err};
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty at t=%0t", tag, $time);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s t=%0t: got dv=%b A=%0d B=%0d vld=%b busy=%b done=%b err=%b, expected dv=%b A=%0d B=%0d vld=%b busy=%b done=%b err=%b",
                         tag, $time, act.dv, act.a, act.b, act.vld, act.busy, act.done, act.err,
                         e.dv, e.a, e.b, e.vld, e.busy, e.done, e.err);
            end
        end
    endtask

    task automatic idle(input string tag);
        tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic rd(input string tag);
        tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    task automatic arm_and_settle(input string tag);
        tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, tag);
        idle(tag);
    endtask

    task automatic load_banks(input int a0, input int b0, input int step);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, 4'(i), 8'(a0 + step * i), 1'b0, 1'b0, 1'b0, "load_a");
            tick(1'b1, 1'b1, 4'(i), 8'(b0 - step * i), 1'b0, 1'b0, 1'b0, "load_b");
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.load_en = 1'b0; bus.load_sel = 1'b0; bus.load_addr = 4'd0; bus.load_data = 8'd0;
        bus.arm = 1'b0; bus.start_compute = 1'b0; bus.read_data = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_a[i] = 8'd0;
            m_b[i] = 8'd0;
        end
        m_state = 0; m_ptr = 0; m_err = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.data_valid, bus.data_in_A, bus.data_in_B, bus.data_out_vld, bus.busy,
             bus.xfer_done, bus.err} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got A=%0d B=%0d vld=%b busy=%b err=%b, expected all 0",
                     bus.data_in_A, bus.data_in_B, bus.data_out_vld, bus.busy, bus.err);
        end
    endtask

    task automatic test_load_arm();
        load_banks(1, 16, 1);
        tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, "arm");
        vectors++;
        if (bus.data_valid !== 1'b1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL arm_pulse: got dv=%b busy=%b, expected dv=1 busy=1", bus.data_valid, bus.busy);
        end
        idle("arm_settle");
        vectors++;
        if (bus.data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arm_pulse_width: got dv=%b, expected 0", bus.data_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) rd("b2b_read");
        vectors++;
        if (bus.xfer_done !== 1'b1 || bus.data_in_A !== 8'd16 || bus.data_in_B !== 8'd1) begin
            miscompares++;
            $display("FAIL b2b_last: got done=%b A=%0d B=%0d, expected done=1 A=16 B=1",
                     bus.xfer_done, bus.data_in_A, bus.data_in_B);
        end
        idle("b2b_after");
        vectors++;
        if (bus.busy !== 1'b0 || bus.xfer_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got busy=%b done=%b, expected 0 0", bus.busy, bus.xfer_done);
        end
    endtask

    task automatic test_every_other();
        arm_and_settle("eo_arm");
        for (int i = 0; i < 16; i++) begin
            rd("eo_read");
            idle("eo_gap");
        end
    endtask

    task automatic test_start_compute();
        arm_and_settle("sc_arm");
        for (int i = 0; i < 5; i++) rd("sc_pre");
        tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, "sc_restart");
        vectors++;
        if (bus.data_in_A !== 8'd1 || bus.data_in_B !== 8'd16) begin
            miscompares++;
            $display("FAIL sc_first: got A=%0d B=%0d, expected A=1 B=16", bus.data_in_A, bus.data_in_B);
        end
        rd("sc_next");
        vectors++;
        if (bus.data_in_A !== 8'd2) begin
            miscompares++;
            $display("FAIL sc_second: got A=%0d, expected A=2", bus.data_in_A);
        end
        for (int i = 0; i < 14; i++) rd("sc_rest");
        idle("sc_end");
    endtask

    task automatic test_errors();
        rd("err_idle_read");
        vectors++;
        if (bus.err !== 1'b1 || bus.data_out_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL err_idle_read: got err=%b vld=%b, expected err=1 vld=0", bus.err, bus.data_out_vld);
        end
        arm_and_settle("err_arm");
        rd("err_read0");
        tick(1'b1, 1'b0, 4'd1, 8'hAA, 1'b0, 1'b0, 1'b0, "err_load_serve");
        tick(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, "err_arm_serve");
        for (int i = 0; i < 15; i++) rd("err_reads");
        idle("err_end");
    endtask

    task automatic test_reset_mid();
        arm_and_settle("rm_arm");
        for (int i = 0; i < 7; i++) rd("rm_pre");
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.data_valid, bus.data_in_A, bus.data_in_B, bus.data_out_vld, bus.busy,
             bus.xfer_done, bus.err} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got A=%0d B=%0d vld=%b busy=%b err=%b, expected all 0",
                     bus.data_in_A, bus.data_in_B, bus.data_out_vld, bus.busy, bus.err);
        end
        do_reset();
        // banks must read back cleared before the reload
        arm_and_settle("rm_clear_arm");
        for (int i = 0; i < 16; i++) rd("rm_cleared");
        load_banks(3, 200, 5);
        arm_and_settle("rm_rearm");
        for (int i = 0; i < 16; i++) rd("rm_reads");
        idle("rm_end");
    endtask

    initial begin
        test_reset();
        test_load_arm();
        test_back_to_back();
        test_every_other();
        test_start_compute();
        test_errors();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
